vga_pattern_gen: RTL and testbench

//  Parametrised VGA test-pattern generator: successor to the fixed 8-bar ROM image generator.

---
 rtl/vga_pattern_gen_if.sv | 15 +
 rtl/vga_pattern_gen.sv | 163 ++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_gen_if.sv
// Pixel-stream bundle between the VGA timing counter, the pattern generator and the DAC.
// The timing side drives position/blanking; the generator returns registered colour and DE.
interface vga_pattern_gen_if;
   logic        IAA;
   logic        VS;
   logic [10:0] HCNT;
   logic [10:0] VCNT;
   logic [7:0]  R;
   logic [7:0]  G;
   logic [7:0]  B;
   logic        DE;

   modport master (output IAA, VS, HCNT, VCNT, input  R, G, B, DE);
   modport slave  (input  IAA, VS, HCNT, VCNT, output R, G, B, DE);
endinterface

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: vertical/horizontal bars, checkerboard, bars with a moving square.
// Two register stages from timing inputs to RGB/DE; mode and square position change only at frame start.
module vga_pattern_gen #(
   parameter int H_VISIBLE = 640,
   parameter int V_VISIBLE = 480,
   parameter int NUM_BARS  = 8,
   parameter int CHK_LOG2  = 5,
   parameter int SQ_SIZE   = 64,
   parameter int SQ_Y0     = 208,
   parameter int SQ_STEP   = 4
) (
   input  logic             CLK,
   input  logic             rst,
   vga_pattern_gen_if.slave vga,
   input  logic [1:0]       MODE,
   input  logic             MOVE_N,
   input  logic [8:0]       SQ_COLOR
);

   typedef enum logic [1:0] {
      MODE_VBARS  = 2'd0,
      MODE_HBARS  = 2'd1,
      MODE_CHECK  = 2'd2,
      MODE_SQUARE = 2'd3
   } mode_e;

   localparam int BAR_W = H_VISIBLE / NUM_BARS;
   localparam int BAR_H = V_VISIBLE / NUM_BARS;

   // Frame control state
   logic        vs_q, vs_d;
   logic        mv_meta_q, mv_meta_d;
   logic        mv_sync_q, mv_sync_d;
   mode_e       mode_q, mode_d;
   logic [10:0] sq_x_q, sq_x_d;

   // Stage 1
   logic [3:0]  vidx_q, vidx_d;
   logic [3:0]  hidx_q, hidx_d;
   logic        chk_q, chk_d;
   logic        insq_q, insq_d;
   logic        iaa_q, iaa_d;

   // Stage 2
   logic [7:0]  r_q, r_d;
   logic [7:0]  g_q, g_d;
   logic [7:0]  b_q, b_d;
   logic        de_q, de_d;

   logic        tick;
   logic [11:0] sq_nxt;
   logic [10:0] vquot, hquot;
   logic [11:0] h12, v12, x12;
   logic [3:0]  sel_idx;
   logic [2:0]  on;
   logic [7:0]  lvl;

   // NOTE: every variable assigned here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      vs_d      = vga.VS;
      mv_meta_d = MOVE_N;
      mv_sync_d = mv_meta_q;
      mode_d    = mode_q;
      sq_x_d    = sq_x_q;

      // vs_q resets to 0, so a high VS after reset release cannot look like a falling edge.
      tick   = vs_q & ~vga.VS;
      sq_nxt = {1'b0, sq_x_q} + 12'(SQ_STEP);
      if (tick) begin
         mode_d = mode_e'(MODE);
         if (!mv_sync_q) begin
            if (sq_nxt + 12'(SQ_SIZE) > 12'(H_VISIBLE)) sq_x_d = '0;
            else                                        sq_x_d = sq_nxt[10:0];
         end
      end

      vquot  = vga.HCNT / 11'(BAR_W);
      hquot  = vga.VCNT / 11'(BAR_H);
      vidx_d = (vquot > 11'(NUM_BARS - 1)) ? 4'(NUM_BARS - 1) : vquot[3:0];
      hidx_d = (hquot > 11'(NUM_BARS - 1)) ? 4'(NUM_BARS - 1) : hquot[3:0];
      chk_d  = vga.HCNT[CHK_LOG2] ^ vga.VCNT[CHK_LOG2];
      h12    = {1'b0, vga.HCNT};
      v12    = {1'b0, vga.VCNT};
      x12    = {1'b0, sq_x_q};
      insq_d = (h12 >= x12) && (h12 < x12 + 12'(SQ_SIZE)) &&
               (v12 >= 12'(SQ_Y0)) && (v12 < 12'(SQ_Y0 + SQ_SIZE));
      iaa_d  = vga.IAA;

      sel_idx = (mode_q == MODE_HBARS) ? hidx_q : vidx_q;
      unique case (sel_idx[2:0])
         3'd0:    on = 3'b111;
         3'd1:    on = 3'b110;
         3'd2:    on = 3'b011;
         3'd3:    on = 3'b010;
         3'd4:    on = 3'b101;
         3'd5:    on = 3'b100;
         3'd6:    on = 3'b001;
         default: on = 3'b000;
      endcase
      // Bars 8..15 repeat the palette at half brightness.
      lvl = sel_idx[3] ? 8'h7F : 8'hFF;
      r_d = on[2] ? lvl : 8'h00;
      g_d = on[1] ? lvl : 8'h00;
      b_d = on[0] ? lvl : 8'h00;
      if (mode_q == MODE_CHECK) begin
         r_d = chk_q ? 8'hFF : 8'h00;
         g_d = chk_q ? 8'hFF : 8'h00;
         b_d = chk_q ? 8'hFF : 8'h00;
      end
      if (mode_q == MODE_SQUARE && insq_q) begin
         r_d = {SQ_COLOR[8:6], 5'b0};
         g_d = {SQ_COLOR[5:3], 5'b0};
         b_d = {SQ_COLOR[2:0], 5'b0};
      end
      if (!iaa_q) begin
         r_d = 8'h00;
         g_d = 8'h00;
         b_d = 8'h00;
      end
      de_d = iaa_q;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         vs_q      <= 1'b0;
         mv_meta_q <= 1'b1;
         mv_sync_q <= 1'b1;
         mode_q    <= MODE_VBARS;
         sq_x_q    <= '0;
         vidx_q    <= '0;
         hidx_q    <= '0;
         chk_q     <= 1'b0;
         insq_q    <= 1'b0;
         iaa_q     <= 1'b0;
         r_q       <= '0;
         g_q       <= '0;
         b_q       <= '0;
         de_q      <= 1'b0;
      end else begin
         vs_q      <= vs_d;
         mv_meta_q <= mv_meta_d;
         mv_sync_q <= mv_sync_d;
         mode_q    <= mode_d;
         sq_x_q    <= sq_x_d;
         vidx_q    <= vidx_d;
         hidx_q    <= hidx_d;
         chk_q     <= chk_d;
         insq_q    <= insq_d;
         iaa_q     <= iaa_d;
         r_q       <= r_d;
         g_q       <= g_d;
         b_q       <= b_d;
         de_q      <= de_d;
      end
   end

   assign vga.R  = r_q;
   assign vga.G  = g_q;
   assign vga.B  = b_q;
   assign vga.DE = de_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: an 8-bar and a 16-bar instance share one pixel stream; a frame-level
// model predicts every pixel, the driver queues predictions and a monitor compares 2 cycles later.
module tb_vga_pattern_gen;

   logic       CLK = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] MODE = 2'd0;
   logic       MOVE_N = 1'b1;
   logic [8:0] SQ_COLOR = 9'd0;

   vga_pattern_gen_if if8 ();
   vga_pattern_gen_if if16 ();

   assign if16.IAA  = if8.IAA;
   assign if16.VS   = if8.VS;
   assign if16.HCNT = if8.HCNT;
   assign if16.VCNT = if8.VCNT;

   vga_pattern_gen u_dut8 (
      .CLK(CLK), .rst(rst), .vga(if8.slave),
      .MODE(MODE), .MOVE_N(MOVE_N), .SQ_COLOR(SQ_COLOR));

   vga_pattern_gen #(.NUM_BARS(16)) u_dut16 (
      .CLK(CLK), .rst(rst), .vga(if16.slave),
      .MODE(MODE), .MOVE_N(MOVE_N), .SQ_COLOR(SQ_COLOR));

   always #5 CLK = ~CLK;

   typedef struct {
      logic [23:0] e8;
      logic [23:0] e16;
      logic        de;
      string       name;
   } item_t;

   item_t sb[$];
   int    tests = 0;
   int    fails = 0;
   bit    mon_en = 1'b0;
   bit    rel = 1'b0;

   // Frame-level model state
   int         m_mode = 0;
   int         m_sqx = 0;
   logic [8:0] m_sqc = 9'd0;
   logic [2:0] pal [8] = '{3'b111, 3'b110, 3'b011, 3'b010, 3'b101, 3'b100, 3'b001, 3'b000};

   function automatic logic [23:0] model_rgb(input int nb, input int h, input int v, input bit iaa);
      int idx;
      logic [2:0] bits;
      logic [7:0] lvl;
      if (!iaa) return 24'h000000;
      if (m_mode == 2) return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      if (m_mode == 3 && h >= m_sqx && h < m_sqx + 64 && v >= 208 && v < 272)
         return {m_sqc[8:6], 5'b0, m_sqc[5:3], 5'b0, m_sqc[2:0], 5'b0};
      idx = (m_mode == 1) ? v / (480 / nb) : h / (640 / nb);
      if (idx > nb - 1) idx = nb - 1;
      bits = pal[idx % 8];
      lvl  = (idx >= 8) ? 8'h7F : 8'hFF;
      return {bits[2] ? lvl : 8'h00, bits[1] ? lvl : 8'h00, bits[0] ? lvl : 8'h00};
   endfunction

   task automatic drive(input int h, input int v, input bit iaa, input bit vs, input string name);
      item_t it;
      @(negedge CLK);
      if (rel) begin
         rst    = 1'b1;
         mon_en = 1'b1;
         rel    = 1'b0;
      end
      if8.HCNT = 11'(h);
      if8.VCNT = 11'(v);
      if8.IAA  = iaa;
      if8.VS   = vs;
      if (mon_en) begin
         it.e8   = model_rgb(8, h, v, iaa);
         it.e16  = model_rgb(16, h, v, iaa);
         it.de   = iaa;
         it.name = name;
         sb.push_back(it);
      end
   endtask

   task automatic frame_sync(input logic [1:0] mode, input logic mv, input logic [8:0] sqc);
      repeat (2) drive(0, 0, 1'b0, 1'b1, "blank");
      MODE = mode;
      MOVE_N = mv;
      SQ_COLOR = sqc;
      m_sqc = sqc;
      repeat (3) drive(0, 0, 1'b0, 1'b1, "blank");
      drive(0, 0, 1'b0, 1'b0, "vs_fall");
      m_mode = int'(mode);
      if (!mv) begin
         if (m_sqx + 4 + 64 > 640) m_sqx = 0;
         else                      m_sqx = m_sqx + 4;
      end
      drive(0, 0, 1'b0, 1'b0, "vs_low");
      repeat (2) drive(0, 0, 1'b0, 1'b1, "back_porch");
   endtask

   task automatic reset_mid();
      @(posedge CLK);
      #3;
      mon_en = 1'b0;
      sb.delete();
      rst = 1'b0;
      m_mode = 0;
      m_sqx = 0;
      #1;
      tests++;
      if ({if8.R, if8.G, if8.B, if8.DE, if16.R, if16.G, if16.B, if16.DE} !== '0) begin
         fails++;
         $display("FAIL reset_async: got rgb8=%h de8=%b rgb16=%h de16=%b, required all 0",
                  {if8.R, if8.G, if8.B}, if8.DE, {if16.R, if16.G, if16.B}, if16.DE);
      end
      repeat (2) drive(100, 208, 1'b1, 1'b1, "in_reset");
      rel = 1'b1;
   endtask

   // Monitor: each output cycle pairs with the prediction queued two pixels earlier.
   always @(posedge CLK) begin
      item_t e;
      logic [23:0] got8, got16;
      #1;
      if (mon_en && sb.size() >= 2) begin
         e = sb.pop_front();
         got8  = {if8.R, if8.G, if8.B};
         got16 = {if16.R, if16.G, if16.B};
         tests++;
         if (got8 !== e.e8 || got16 !== e.e16 || if8.DE !== e.de || if16.DE !== e.de) begin
            fails++;
            $display("FAIL %s: got rgb8=%h rgb16=%h de=%b/%b, required rgb8=%h rgb16=%h de=%b",
                     e.name, got8, got16, if8.DE, if16.DE, e.e8, e.e16, e.de);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, required normal completion");
      $fatal(1, "watchdog");
   end

   initial begin
      if8.HCNT = '0;
      if8.VCNT = '0;
      if8.IAA  = 1'b0;
      if8.VS   = 1'b1;
      #1;
      tests++;
      if ({if8.R, if8.G, if8.B, if8.DE} !== '0) begin
         fails++;
         $display("FAIL reset_state: got rgb=%h de=%b, required 000000 de=0", {if8.R, if8.G, if8.B}, if8.DE);
      end
      repeat (3) @(negedge CLK);
      rel = 1'b1;

      // Vertical bars across one full line, then blanking tail
      frame_sync(2'd0, 1'b1, 9'h1A5);
      for (int h = 0; h < 640; h++) drive(h, 10, 1'b1, 1'b1, "vbar_sweep");
      for (int h = 640; h < 644; h++) drive(h, 10, 1'b0, 1'b1, "hblank");
      drive(360, 10, 1'b1, 1'b1, "bar16_idx9");
      drive(0, 10, 1'b1, 1'b1, "bar16_idx0");

      // Mode request mid-frame must not take effect before VS falls
      drive(0, 100, 1'b1, 1'b1, "pre_mode2");
      MODE = 2'd2;
      for (int h = 0; h < 640; h += 37) drive(h, 100, 1'b1, 1'b1, "hold_vbars");
      frame_sync(2'd2, 1'b1, 9'h1A5);
      drive(0, 0, 1'b1, 1'b1, "chk_0_0");
      drive(32, 0, 1'b1, 1'b1, "chk_32_0");
      drive(32, 32, 1'b1, 1'b1, "chk_32_32");
      drive(31, 31, 1'b1, 1'b1, "chk_31_31");
      drive(639, 479, 1'b1, 1'b1, "chk_corner");

      // Horizontal bars including clamp region beyond the visible area
      frame_sync(2'd1, 1'b1, 9'h1A5);
      foreach (pal[i]) drive(5, i * 60, 1'b1, 1'b1, "hbar_edge");
      drive(5, 59, 1'b1, 1'b1, "hbar_59");
      drive(5, 479, 1'b1, 1'b1, "hbar_479");
      drive(5, 520, 1'b1, 1'b1, "hbar_clamp");
      drive(700, 10, 1'b1, 1'b1, "hbar_h_far");

      // Square overlay after three steps
      for (int k = 0; k < 3; k++) frame_sync(2'd3, 1'b0, 9'b111_000_000);
      frame_sync(2'd3, 1'b1, 9'b111_000_000);
      drive(12, 208, 1'b1, 1'b1, "sq_in");
      drive(76, 208, 1'b1, 1'b1, "sq_right_out");
      drive(75, 271, 1'b1, 1'b1, "sq_corner_in");
      drive(11, 208, 1'b1, 1'b1, "sq_left_out");
      drive(12, 272, 1'b1, 1'b1, "sq_below_out");
      drive(12, 207, 1'b1, 1'b1, "sq_above_out");
      drive(700, 208, 1'b1, 1'b1, "vbar_clamp");

      // Walk the square to the right edge, then wrap
      while (m_sqx != 576) frame_sync(2'd3, 1'b0, 9'b000_111_011);
      drive(576, 208, 1'b1, 1'b1, "sq_at_576");
      drive(639, 271, 1'b1, 1'b1, "sq_edge_in");
      drive(575, 208, 1'b1, 1'b1, "sq_576_left_out");
      frame_sync(2'd3, 1'b0, 9'b000_111_011);
      drive(0, 208, 1'b1, 1'b1, "sq_wrapped");
      drive(576, 208, 1'b1, 1'b1, "sq_old_pos");
      repeat (2) frame_sync(2'd3, 1'b1, 9'b000_111_011);
      drive(0, 208, 1'b1, 1'b1, "sq_hold");
      drive(64, 208, 1'b1, 1'b1, "sq_hold_out");

      // Move to x=40, then reset mid-line
      repeat (10) frame_sync(2'd3, 1'b0, 9'b101_010_110);
      MOVE_N = 1'b1;
      for (int h = 30; h < 60; h++) drive(h, 220, 1'b1, 1'b1, "pre_reset");
      reset_mid();
      drive(40, 220, 1'b1, 1'b1, "post_reset_mode0");
      drive(100, 220, 1'b1, 1'b1, "post_reset_bar1");
      frame_sync(2'd3, 1'b1, 9'b101_010_110);
      drive(0, 208, 1'b1, 1'b1, "post_reset_sq0");
      drive(63, 271, 1'b1, 1'b1, "post_reset_sq_in");
      drive(64, 208, 1'b1, 1'b1, "post_reset_sq_out");

      // Randomised frames
      for (int f = 0; f < 20; f++) begin
         frame_sync(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 9'($urandom));
         for (int p = 0; p < 150; p++)
            drive($urandom_range(0, 700), $urandom_range(0, 520), 1'($urandom_range(0, 3) != 0), 1'b1, "random");
      end

      repeat (3) drive(0, 0, 1'b0, 1'b1, "flush");
      @(posedge CLK);
      #2;
      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
